// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshake, traps and retire counter
module multicycle_controller #(
  parameter int OPC_W    = 6,
  parameter int ALU_OP_W = 3,
  parameter int MEM_TMO  = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPC_W-1:0]    opc,
  input  logic                zero_flag,
  input  logic                mem_ack,
  output logic                ir_write,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_const,
  output logic                mem_read,
  output logic                mem_write,
  output logic                rf_wr_en,
  output logic                rf_in_mem,
  output logic                rf_dst_r2,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                halt,
  output logic [1:0]          err_code,
  output logic [CNT_W-1:0]    retired
);
  localparam int TMO_W = $clog2(MEM_TMO);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t              state_q, state_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          err_q, err_d;
  logic [CNT_W-1:0]    ret_q, ret_d;
  logic [3:0]          cls;
  logic                is_r, is_i, is_mem, is_ld, is_cj, is_bnz, is_jmp, is_ill;
  logic                ir_c, asc_c, mrd_c, mwr_c, rfw_c, rfm_c, dst_c, pcw_c;
  logic [ALU_OP_W-1:0] alu_c;
  logic [1:0]          psrc_c;
  assign cls    = opc_q[OPC_W-1 -: 4];
  assign is_r   = cls[3:2] == 2'b00;
  assign is_i   = cls[3:2] == 2'b01;
  assign is_mem = cls == 4'b1000;
  assign is_ld  = opc_q[OPC_W-5];
  assign is_cj  = cls[3:1] == 3'b101;
  assign is_bnz = cls[0];
  assign is_jmp = cls == 4'b1100;
  assign is_ill = !(is_r || is_i || is_mem || is_cj || is_jmp);
  // next state, trap/timeout bookkeeping and per-state Moore strobes
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ir_c    = 1'b0;
    alu_c   = '0;
    asc_c   = 1'b0;
    mrd_c   = 1'b0;
    mwr_c   = 1'b0;
    rfw_c   = 1'b0;
    rfm_c   = 1'b0;
    dst_c   = 1'b0;
    pcw_c   = 1'b0;
    psrc_c  = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_c    = 1'b1;
        opc_d   = opc;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = is_ill ? S_HALT : S_EXEC;
        err_d   = is_ill ? 2'b01 : err_q;
      end
      S_EXEC: begin
        alu_c   = (is_r || is_i) ? opc_q[ALU_OP_W-1:0] : '0;
        asc_c   = is_i || is_mem;
        pcw_c   = is_cj || is_jmp;
        psrc_c  = is_jmp ? 2'b10 : (is_cj && (is_bnz ^ zero_flag)) ? 2'b01 : 2'b00;
        state_d = is_mem ? S_MEM : (is_cj || is_jmp) ? S_FETCH : S_WB;
      end
      S_MEM: begin
        asc_c   = 1'b1;
        mrd_c   = is_ld;
        mwr_c   = !is_ld;
        state_d = mem_ack ? S_WB : (cnt_q == TMO_W'(MEM_TMO - 1)) ? S_HALT : S_MEM;
        err_d   = (!mem_ack && cnt_q == TMO_W'(MEM_TMO - 1)) ? 2'b10 : err_q;
        cnt_d   = (state_d == S_MEM) ? cnt_q + TMO_W'(1) : '0;
      end
      S_WB: begin
        rfw_c   = !is_mem || is_ld;
        rfm_c   = is_mem && is_ld;
        dst_c   = is_mem && is_ld;
        pcw_c   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    ret_d = ret_q + CNT_W'(pcw_c);
  end
  // state register; reset wins over every state including MEM wait and HALT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 2'b00;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
    end
  end
  // strobes are masked while reset is held so the datapath stays idle even though the state already sits in FETCH
  assign ir_write      = rst_n && ir_c;
  assign alu_op        = rst_n ? alu_c : '0;
  assign alu_src_const = rst_n && asc_c;
  assign mem_read      = rst_n && mrd_c;
  assign mem_write     = rst_n && mwr_c;
  assign rf_wr_en      = rst_n && rfw_c;
  assign rf_in_mem     = rst_n && rfm_c;
  assign rf_dst_r2     = rst_n && dst_c;
  assign pc_write      = rst_n && pcw_c;
  assign pc_src        = rst_n ? psrc_c : 2'b00;
  assign halt          = state_q == S_HALT;
  assign err_code      = err_q;
  assign retired       = ret_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction stream scored against an instruction-level reference model
module tb_multicycle_controller;
  localparam int TMO = 16;
  logic        clk = 1'b0, rst_n = 1'b0, zero_flag = 1'b0, mem_ack = 1'b0;
  logic [5:0]  opc = '0;
  logic        ir_write, alu_src_const, mem_read, mem_write, rf_wr_en, rf_in_mem, rf_dst_r2, pc_write, halt;
  logic [2:0]  alu_op;
  logic [1:0]  pc_src, err_code;
  logic [15:0] retired;
  logic        s_ir_write, s_alu_src_const, s_mem_read, s_mem_write, s_rf_wr_en, s_rf_in_mem, s_rf_dst_r2, s_pc_write, s_halt;
  logic [2:0]  s_alu_op;
  logic [1:0]  s_pc_src, s_err_code;
  logic [3:0]  s_retired;

  multicycle_controller #(.OPC_W(6), .ALU_OP_W(3), .MEM_TMO(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opc(opc), .zero_flag(zero_flag), .mem_ack(mem_ack),
    .ir_write(ir_write), .alu_op(alu_op), .alu_src_const(alu_src_const), .mem_read(mem_read),
    .mem_write(mem_write), .rf_wr_en(rf_wr_en), .rf_in_mem(rf_in_mem), .rf_dst_r2(rf_dst_r2),
    .pc_write(pc_write), .pc_src(pc_src), .halt(halt), .err_code(err_code), .retired(retired));

  multicycle_controller #(.OPC_W(6), .ALU_OP_W(3), .MEM_TMO(TMO), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .opc(opc), .zero_flag(zero_flag), .mem_ack(mem_ack),
    .ir_write(s_ir_write), .alu_op(s_alu_op), .alu_src_const(s_alu_src_const), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .rf_wr_en(s_rf_wr_en), .rf_in_mem(s_rf_in_mem), .rf_dst_r2(s_rf_dst_r2),
    .pc_write(s_pc_write), .pc_src(s_pc_src), .halt(s_halt), .err_code(s_err_code), .retired(s_retired));

  always #5 clk = ~clk;

  typedef struct {
    bit hlt;
    int err, lat, psrc, rfw, rfm, dst, mrd, mwr, asc, alu, ret;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0, n_ret = 0;

  function automatic void chk(string nm, longint got, longint expv);
    n_chk++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, expv, $time);
  endfunction

  // instruction-level summary: latency in cycles, strobe activity counts and final PC source
  function automatic exp_t model(logic [5:0] o, int w, logic zf);
    exp_t e;
    e = '{default: 0};
    if (!o[5]) begin
      e.lat = 4; e.rfw = 1; e.alu = int'(o[2:0]); e.asc = int'(o[4]);
    end else if (o[5:2] == 4'b1000) begin
      if (w <= TMO) begin
        e.lat = 4 + w; e.asc = 1 + w;
        if (o[1]) begin e.mrd = w; e.rfw = 1; e.rfm = 1; e.dst = 1; end
        else e.mwr = w;
      end else begin
        e.hlt = 1; e.err = 2; e.lat = 4 + TMO; e.asc = 1 + TMO;
        if (o[1]) e.mrd = TMO; else e.mwr = TMO;
      end
    end else if (o[5:3] == 3'b101) begin
      e.lat = 3; e.psrc = (o[2] ^ zf) ? 1 : 0;
    end else if (o[5:2] == 4'b1100) begin
      e.lat = 3; e.psrc = 2;
    end else begin
      e.hlt = 1; e.err = 1; e.lat = 3;
    end
    return e;
  endfunction

  // monitor: accumulates one instruction from ir_write to pc_write/halt, then scores it
  bit active = 0, rst_seen = 0;
  int cyc, a_rfw, a_rfm, a_dst, a_mrd, a_mwr, a_asc, a_alu, last_err = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (rst_seen)
          chk("reset_outputs", longint'({ir_write, alu_op, alu_src_const, mem_read, mem_write, rf_wr_en, rf_in_mem,
              rf_dst_r2, pc_write, pc_src, halt, err_code, retired, s_retired}), 0);
        rst_seen = 1; active = 0; q.delete();
      end else begin
        rst_seen = 0;
        if (ir_write) begin
          if (active) chk("refetch_before_retire", 1, 0);
          active = 1; cyc = 0; a_rfw = 0; a_rfm = 0; a_dst = 0; a_mrd = 0; a_mwr = 0; a_asc = 0; a_alu = 0;
        end
        if (active) begin
          cyc++;
          a_rfw += int'(rf_wr_en); a_rfm |= int'(rf_in_mem); a_dst |= int'(rf_dst_r2);
          a_mrd += int'(mem_read); a_mwr += int'(mem_write); a_asc += int'(alu_src_const); a_alu |= int'(alu_op);
          if (pc_write || halt) begin
            if (q.size() == 0) chk("unexpected_event", 1, 0);
            else begin
              e = q.pop_front();
              chk("halt_vs_retire", halt, e.hlt);
              chk("latency", cyc, e.lat);
              chk("rf_wr_en_cycles", a_rfw, e.rfw);
              chk("rf_in_mem", a_rfm, e.rfm);
              chk("rf_dst_r2", a_dst, e.dst);
              chk("mem_read_cycles", a_mrd, e.mrd);
              chk("mem_write_cycles", a_mwr, e.mwr);
              chk("alu_src_const_cycles", a_asc, e.asc);
              chk("alu_op", a_alu, e.alu);
              if (halt) begin
                chk("err_code", err_code, e.err);
                last_err = int'(err_code);
              end else begin
                chk("pc_src", pc_src, e.psrc);
                chk("retired", retired, e.ret % 65536);
                chk("retired_w4", s_retired, e.ret % 16);
              end
            end
            active = 0;
          end else if (cyc > 60) begin
            chk("instr_stuck", 1, 0);
            active = 0;
          end
        end else if (halt) begin
          chk("halt_quiet", longint'({ir_write, alu_op, alu_src_const, mem_read, mem_write, rf_wr_en, rf_in_mem,
              rf_dst_r2, pc_write, pc_src}), 0);
          chk("err_held", err_code, last_err);
        end
      end
    end
  end

  // inputs change 1 time unit after the rising edge, so the current cycle's state is already visible
  task automatic do_reset();
    mem_ack = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_ret = 0;
    #1;
  endtask

  task automatic run_instr(input logic [5:0] o, input int w, input logic zf, input int abort_at);
    exp_t e;
    int t = 0, mc = 0;
    while (!ir_write && t < 80) begin @(posedge clk); #1; t++; end
    if (!ir_write) begin chk("fetch_wait", 0, 1); return; end
    chk("retired_at_fetch", retired, n_ret % 65536);
    chk("retired_w4_at_fetch", s_retired, n_ret % 16);
    opc = o; zero_flag = zf; mem_ack = 1'b0;
    e = model(o, w, zf);
    e.ret = n_ret;
    if (!e.hlt) n_ret++;
    q.push_back(e);
    t = 0;
    do begin
      @(posedge clk); #1; t++;
      opc = 6'($urandom);
      mem_ack = 1'b0;
      if (mem_read || mem_write) begin
        mc++;
        mem_ack = (mc == w);
        if (mc == abort_at) begin do_reset(); return; end
      end
    end while (!ir_write && !halt && t < 80);
    if (halt) begin
      repeat (3) @(posedge clk);
      #1 do_reset();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    do_reset();
    run_instr(6'b000010, 1, 1'b0, 0);
    run_instr(6'b100010, 3, 1'b0, 0);
    run_instr(6'b101000, 1, 1'b1, 0);
    run_instr(6'b101000, 1, 1'b0, 0);
    run_instr(6'b101100, 1, 1'b0, 0);
    run_instr(6'b101100, 1, 1'b1, 0);
    run_instr(6'b110000, 1, 1'b0, 0);
    run_instr(6'b011101, 1, 1'b0, 0);
    run_instr(6'b100000, TMO, 1'b0, 0);
    run_instr(6'b100010, 1, 1'b0, 0);
    run_instr(6'b100000, TMO + 1, 1'b0, 0);
    run_instr(6'b111111, 1, 1'b0, 0);
    run_instr(6'b100100, 1, 1'b0, 0);
    run_instr(6'b110100, 1, 1'b0, 0);
    run_instr(6'b100010, TMO + 1, 1'b0, 0);
    run_instr(6'b100000, 999, 1'b0, 5);
    for (int i = 0; i < 17; i++) run_instr(6'b110000, 1, 1'b0, 0);
    run_instr(6'b000111, 1, 1'b0, 0);
    for (int i = 0; i < 300; i++)
      run_instr(6'($urandom), int'($urandom_range(1, TMO + 1)), 1'($urandom), 0);
    repeat (2) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
